// File: rtl/and_unit_arbiter.sv
// rtl/and_unit_arbiter.sv - round-robin arbiter sharing one registered AND unit
// Optional grant statistics counter enabled by defining AND_ARB_STATS_EN.
module and_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy
`ifdef AND_ARB_STATS_EN
    ,
    output logic [31:0]              grant_count
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   gnt_id;
    logic              gnt_any;
    logic              grant;
    logic [ID_W-1:0]   id_q;
    logic [WIDTH-1:0]  a_q, b_q;
    int                idx;

    // Search starts at rr_ptr and wraps; first valid requester found wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_any && !rst) begin
                    req_ready[gnt_id] = 1'b1;
                    grant             = 1'b1;
                    state_nxt         = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                a_q    <= req_a[int'(gnt_id)*WIDTH +: WIDTH];
                b_q    <= req_b[int'(gnt_id)*WIDTH +: WIDTH];
                id_q   <= gnt_id;
                rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
            end
            if (state == EXEC) begin
                rsp_valid <= 1'b1;
                rsp_data  <= a_q & b_q;
                rsp_id    <= id_q;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef AND_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)        grant_count <= '0;
        else if (grant) grant_count <= grant_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_and_unit_arbiter.sv
// tb/tb_and_unit_arbiter.sv - randomized scoreboard bench for and_unit_arbiter
// Reference model tracks pending requests, rotation pointer and op phase.
module tb_and_unit_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_data;
    logic [1:0]     rsp_id;
    logic           busy;
`ifdef AND_ARB_STATS_EN
    logic [31:0]    grant_count;
`endif

    and_unit_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
`ifdef AND_ARB_STATS_EN
        , .grant_count(grant_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        int           id;
        int           t;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    // model state
    bit [N-1:0]  pend;
    logic [W-1:0] a_m[N];
    logic [W-1:0] b_m[N];
    int          ptr = 0;
    int          phase = 0;      // 0 idle, 1 computing, 2 waiting for accept
    int          gcount = 0;
    bit          rst_d;
    bit          rdy_d;

    always @(negedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called just after a falling edge; drives inputs, checks, advances model one cycle.
    task automatic cycle();
        int g;
        int ix;
        logic [N-1:0] exp_rdy;
        rst       = rst_d;
        rsp_ready = rdy_d;
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = pend[i];
            req_a[i*W +: W]    = a_m[i];
            req_b[i*W +: W]    = b_m[i];
        end
        #1;
        g = -1;
        if (!rst_d && phase == 0) begin
            for (int k = 0; k < N; k++) begin
                ix = (ptr + k) % N;
                if (g < 0 && pend[ix]) g = ix;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("busy", 64'(busy), 64'(phase != 0));
        if (rst_d) begin
            phase  = 0;
            ptr    = 0;
            gcount = 0;
            sb.delete();
        end else begin
            case (phase)
                0: if (g >= 0) begin
                    sb.push_back('{d: a_m[g] & b_m[g], id: g, t: cyc + 2});
                    ptr     = (g + 1) % N;
                    pend[g] = 1'b0;
                    gcount++;
                    phase   = 1;
                end
                1: phase = 2;
                default: if (rdy_d) phase = 0;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic drain();
        pend  = '0;
        rdy_d = 1'b1;
        for (int i = 0; i < 10 && phase != 0; i++) cycle();
        cycle();
        chk("drain_idle", 64'(phase), 64'd0);
    endtask

    // Monitor: independent of stimulus, compares DUT responses with the scoreboard.
    initial begin : monitor
        logic         pv, pr;
        logic [W-1:0] pd;
        logic [1:0]   pi;
        pv = 1'b0; pr = 1'b0; pd = '0; pi = '0;
        forever begin
            @(negedge clk);
            #2;
            if (pv && pr) chk("valid_drop_after_accept", 64'(rsp_valid), 64'd0);
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp actual=valid required=none (cycle %0d)", cyc);
                end else begin
                    if (!pv) chk("rsp_latency", 64'(cyc), 64'(sb[0].t));
                    if (pv && !pr) begin
                        chk("hold_data", 64'(rsp_data), 64'(pd));
                        chk("hold_id", 64'(rsp_id), 64'(pi));
                    end
                    if (rsp_ready) begin
                        chk("rsp_data", 64'(rsp_data), 64'(sb[0].d));
                        chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
                        void'(sb.pop_front());
                    end
                end
            end
            pv = rsp_valid; pr = rsp_ready; pd = rsp_data; pi = rsp_id;
        end
    end

    initial begin
        rst = 1'b1; rsp_ready = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        for (int i = 0; i < N; i++) begin a_m[i] = '0; b_m[i] = '0; end
        pend = 4'b0001; rst_d = 1'b1; rdy_d = 1'b0;
        @(negedge clk);
        cycle();
        cycle();
        rst_d = 1'b0; pend = '0;
        #1;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_data", 64'(rsp_data), 64'd0);
        chk("reset_rsp_id", 64'(rsp_id), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        @(negedge clk);

        // single request from requester 2
        a_m[2] = 32'hF0F0_FFFF; b_m[2] = 32'h0FF0_00FF; pend = 4'b0100; rdy_d = 1'b1;
        cycle();
        chk("t1_expected_and", 64'(a_m[2] & b_m[2]), 64'h00F0_00FF);
        drain();

        // wrap from pointer 3: grant 3 then 0
        pend = 4'b1001; rdy_d = 1'b1;
        for (int i = 0; i < 7; i++) cycle();
        drain();

        // all four requesting continuously
        for (int i = 0; i < 20; i++) begin
            for (int r = 0; r < N; r++) if (!pend[r]) begin
                pend[r] = 1'b1; a_m[r] = $urandom; b_m[r] = $urandom;
            end
            cycle();
        end
        drain();

        // backpressure: hold for several cycles with every requester waiting
        pend = 4'b0010; a_m[1] = $urandom; b_m[1] = $urandom; rdy_d = 1'b0;
        cycle();
        pend = 4'b1111;
        for (int i = 0; i < 7; i++) cycle();
        rdy_d = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        drain();

        // reset while computing drops the op
        pend = 4'b0010; rdy_d = 1'b1;
        cycle();
        rst_d = 1'b1;
        cycle();
        rst_d = 1'b0;
        chk("rst_exec_busy", 64'(busy), 64'd0);
        chk("rst_exec_rsp_valid", 64'(rsp_valid), 64'd0);
        pend = 4'b1001;
        for (int i = 0; i < 4; i++) cycle();
        drain();

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            for (int r = 0; r < N; r++) begin
                if (!pend[r] && ($urandom % 4 == 0)) begin
                    pend[r] = 1'b1; a_m[r] = $urandom; b_m[r] = $urandom;
                end else if (pend[r] && ($urandom % 16 == 0)) begin
                    pend[r] = 1'b0;
                end
            end
            rdy_d = ($urandom % 2) == 0;
            cycle();
        end
        drain();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
`ifdef AND_ARB_STATS_EN
        chk("grant_count", 64'(grant_count), 64'(gcount));
        rst_d = 1'b1; cycle(); rst_d = 1'b0;
        chk("grant_count_reset", 64'(grant_count), 64'd0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
